// File: rtl/cmac_bringup_pkg.sv
// Shared state codes, state width and default refclk bounds for the CMAC bring-up sequencer.
package cmac_bringup_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE       = 3'd0,
    ST_RESET_HOLD = 3'd1,
    ST_WAIT_LOCK  = 3'd2,
    ST_WAIT_ALIGN = 3'd3,
    ST_RESTART    = 3'd4,
    ST_RUN        = 3'd5,
    ST_RETRY      = 3'd6,
    ST_FAIL       = 3'd7
  } state_e;

  localparam logic [31:0] FREQ_MIN_DEF = 32'd161100000;
  localparam logic [31:0] FREQ_MAX_DEF = 32'd161170000;

  function automatic logic freq_in_range(input logic [31:0] f, input logic [31:0] lo,
                                         input logic [31:0] hi);
    return (f >= lo) && (f <= hi);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bank for asynchronous status inputs; flops clear to 0 on reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cmac_bringup_ctrl.sv
// CMAC bring-up sequencer: timed sys_reset, lock/align waits, restart pulse, bounded retries.
// Define FREQ_CHECK_EN to gate lock acceptance and RUN on the measured refclk frequency.
//
//   state       | meaning
//   IDLE        | CMAC held in reset, waiting for enable
//   RESET_HOLD  | sys_reset asserted for RST_CYCLES
//   WAIT_LOCK   | waiting for rx_gt_locked (and freq_ok), bounded by timeout
//   WAIT_ALIGN  | waiting for rx_aligned, bounded by timeout
//   RESTART     | lbus restart pulse for PULSE_CYCLES
//   RUN         | link up, traffic allowed
//   RETRY       | one-cycle decision: retry again or give up
//   FAIL        | sticky failure until enable drops
module cmac_bringup_ctrl
  import cmac_bringup_pkg::*;
#(
  parameter int unsigned RST_CYCLES     = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 100000000,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned PULSE_CYCLES   = 16,
  parameter logic [31:0] FREQ_MIN       = FREQ_MIN_DEF,
  parameter logic [31:0] FREQ_MAX       = FREQ_MAX_DEF
) (
  input  logic                init_clk,
  input  logic                sys_reset,
  input  logic                enable,
  input  logic                loopback_req,
  input  logic                send_req,
  input  logic                rx_gt_locked,
  input  logic                rx_aligned,
  input  logic                rx_data_fail,
  input  logic                freq_update,
  input  logic [31:0]         freq_value,
  output logic                cmac_sys_reset,
  output logic                cmac_restart,
  output logic                cmac_send_pkts,
  output logic                cmac_loopback_en,
  output logic [STATE_W-1:0]  state,
  output logic [3:0]          retry_cnt,
  output logic                link_up,
  output logic                link_fail,
  output logic [15:0]         fail_events
);

  localparam logic [31:0] RST_LAST   = 32'(RST_CYCLES - 1);
  localparam logic [31:0] TO_LAST    = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] PULSE_LAST = 32'(PULSE_CYCLES - 1);
  localparam logic [3:0]  RETRY_MAX  = 4'(MAX_RETRIES);

  state_e      state_q, state_nxt;
  logic [31:0] phase_cnt;
  logic [2:0]  sync_q;
  logic        lock_s, aligned_s, dfail_s, dfail_prev;
  logic        freq_ok, freq_bad_run;
  logic        state_chg, idle_exit, timeout;

  sync_2ff #(.WIDTH(3)) u_sync (
    .clk (init_clk),
    .rst (sys_reset),
    .d   ({rx_data_fail, rx_aligned, rx_gt_locked}),
    .q   (sync_q)
  );

  assign {dfail_s, aligned_s, lock_s} = sync_q;
  assign state     = state_q;
  assign state_chg = (state_nxt != state_q);
  assign idle_exit = (state_q == ST_IDLE) && (state_nxt == ST_RESET_HOLD);
  assign timeout   = (phase_cnt == TO_LAST);

`ifdef FREQ_CHECK_EN
  logic freq_in;
  assign freq_in      = freq_in_range(freq_value, FREQ_MIN, FREQ_MAX);
  assign freq_bad_run = freq_update && !freq_in;

  // Each new attempt must see a fresh in-range measurement before lock is accepted.
  always_ff @(posedge init_clk or posedge sys_reset) begin
    if (sys_reset)
      freq_ok <= 1'b0;
    else if (state_nxt == ST_RESET_HOLD && state_q != ST_RESET_HOLD)
      freq_ok <= 1'b0;
    else if (freq_update)
      freq_ok <= freq_in;
  end
`else
  logic freq_unused;
  assign freq_unused  = ^{freq_update, freq_value, FREQ_MIN, FREQ_MAX};
  assign freq_ok      = 1'b1;
  assign freq_bad_run = 1'b0;
`endif

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:       state_nxt = ST_RESET_HOLD;
      ST_RESET_HOLD: if (phase_cnt == RST_LAST) state_nxt = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (lock_s && freq_ok)  state_nxt = ST_WAIT_ALIGN;
        else if (timeout)       state_nxt = ST_RETRY;
      end
      ST_WAIT_ALIGN: begin
        if (aligned_s)                state_nxt = ST_RESTART;
        else if (!lock_s || timeout)  state_nxt = ST_RETRY;
      end
      ST_RESTART:    if (phase_cnt == PULSE_LAST) state_nxt = ST_RUN;
      ST_RUN:        if (!aligned_s || !lock_s || freq_bad_run) state_nxt = ST_RETRY;
      ST_RETRY:      state_nxt = (retry_cnt == RETRY_MAX) ? ST_FAIL : ST_RESET_HOLD;
      ST_FAIL:       state_nxt = ST_FAIL;
      default:       state_nxt = ST_IDLE;
    endcase
    // enable low wins over everything, including a restart pulse in flight
    if (!enable) state_nxt = ST_IDLE;
  end

  always_ff @(posedge init_clk or posedge sys_reset) begin
    if (sys_reset) begin
      state_q    <= ST_IDLE;
      phase_cnt  <= '0;
      dfail_prev <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      phase_cnt  <= state_chg ? 32'd0 : phase_cnt + 32'd1;
      dfail_prev <= dfail_s;
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge init_clk or posedge sys_reset) begin
    if (sys_reset) begin
      cmac_sys_reset   <= 1'b1;
      cmac_restart     <= 1'b0;
      cmac_send_pkts   <= 1'b0;
      cmac_loopback_en <= 1'b0;
      retry_cnt        <= '0;
      link_up          <= 1'b0;
      link_fail        <= 1'b0;
      fail_events      <= '0;
    end else begin
      cmac_sys_reset <= (state_nxt == ST_IDLE) || (state_nxt == ST_RESET_HOLD) ||
                        (state_nxt == ST_FAIL);
      cmac_restart   <= (state_nxt == ST_RESTART);
      cmac_send_pkts <= (state_nxt == ST_RUN) && send_req;
      link_up        <= (state_nxt == ST_RUN);
      link_fail      <= (state_nxt == ST_FAIL);
      if (idle_exit) begin
        cmac_loopback_en <= loopback_req;
        retry_cnt        <= '0;
        fail_events      <= '0;
      end else begin
        if (state_q == ST_RETRY && state_nxt == ST_RESET_HOLD)
          retry_cnt <= retry_cnt + 4'd1;
        else if (state_nxt == ST_RUN && state_q != ST_RUN)
          retry_cnt <= '0;
        if (state_q == ST_RUN && dfail_s && !dfail_prev && fail_events != 16'hFFFF)
          fail_events <= fail_events + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_cmac_bringup_ctrl.sv
// Randomized scenario bench for cmac_bringup_ctrl; expected state traces are built per scenario.
module tb_cmac_bringup_ctrl;

  logic        init_clk = 1'b0;
  logic        sys_reset = 1'b1;
  logic        enable = 1'b0, loopback_req = 1'b0, send_req = 1'b0;
  logic        rx_gt_locked = 1'b0, rx_aligned = 1'b0, rx_data_fail = 1'b0;
  logic        freq_update = 1'b1;
  logic [31:0] freq_value = 32'd161132812;
  logic        cmac_sys_reset, cmac_restart, cmac_send_pkts, cmac_loopback_en;
  logic [2:0]  state;
  logic [3:0]  retry_cnt;
  logic        link_up, link_fail;
  logic [15:0] fail_events;

  cmac_bringup_ctrl #(
    .RST_CYCLES(8), .TIMEOUT_CYCLES(100), .MAX_RETRIES(2), .PULSE_CYCLES(4)
  ) dut (
    .init_clk(init_clk), .sys_reset(sys_reset), .enable(enable),
    .loopback_req(loopback_req), .send_req(send_req),
    .rx_gt_locked(rx_gt_locked), .rx_aligned(rx_aligned), .rx_data_fail(rx_data_fail),
    .freq_update(freq_update), .freq_value(freq_value),
    .cmac_sys_reset(cmac_sys_reset), .cmac_restart(cmac_restart),
    .cmac_send_pkts(cmac_send_pkts), .cmac_loopback_en(cmac_loopback_en),
    .state(state), .retry_cnt(retry_cnt), .link_up(link_up), .link_fail(link_fail),
    .fail_events(fail_events)
  );

  always #5 init_clk = ~init_clk;

  int n_checks = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model: expected state per cycle plus quantities derived from the state trace
  int   exp_q[$];
  int   m_prev = 0, m_retry = 0, m_fe = 0;
  logic m_lb = 1'b0;
  logic f1 = 1'b0, f2 = 1'b0, f3 = 1'b0;

  task automatic seg(input int code, input int n);
    repeat (n) exp_q.push_back(code);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_prev = 0; m_retry = 0; m_fe = 0; m_lb = 1'b0;
    f1 = 1'b0; f2 = 1'b0; f3 = 1'b0;
  endtask

  task automatic step();
    @(posedge init_clk);
    #1;
  endtask

  task automatic cyc();
    int   e;
    logic send_b, lb_b, f_now;
    send_b = send_req;
    lb_b   = loopback_req;
    f_now  = rx_data_fail;
    step();
    e = (exp_q.size() > 0) ? exp_q.pop_front() : m_prev;
    if (m_prev == 0 && e == 1) begin m_retry = 0; m_fe = 0; m_lb = lb_b; end
    if (m_prev == 6 && e == 1) m_retry++;
    if (e == 5 && m_prev != 5) m_retry = 0;
    if (m_prev == 5 && f2 && !f3 && m_fe < 65535) m_fe++;
    f3 = f2; f2 = f1; f1 = f_now;
    check("state", state, e);
    check("sys_reset", cmac_sys_reset, (e == 0 || e == 1 || e == 7));
    check("restart", cmac_restart, (e == 4));
    check("link_up", link_up, (e == 5));
    check("link_fail", link_fail, (e == 7));
    check("send_pkts", cmac_send_pkts, (e == 5) && send_b);
    check("loopback_en", cmac_loopback_en, m_lb);
    check("retry_cnt", retry_cnt, m_retry);
    check("fail_events", fail_events, m_fe);
    m_prev = e;
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  int L, A, ta, tr, npulse, j, x;
  localparam int NP = 65540;

  initial begin
    // power-on reset values
    repeat (3) @(posedge init_clk);
    #1;
    check("rst_state", state, 0);
    check("rst_sys_reset", cmac_sys_reset, 1);
    check("rst_restart", cmac_restart, 0);
    check("rst_link_up", link_up, 0);
    check("rst_link_fail", link_fail, 0);
    check("rst_fail_events", fail_events, 0);
    sys_reset = 1'b0;
    model_reset();
    seg(0, 2); run(2);

    // normal bring-up with random lock/align timing, traffic and data_fail pulses
    L  = $urandom_range(1, 60);
    A  = $urandom_range(1, 70);
    ta = (L + 3 > 10) ? L + 3 : 10;
    tr = (A + 3 > ta + 1) ? A + 3 : ta + 1;
    npulse = $urandom_range(1, 6);
    seg(1, 8); seg(2, ta - 9); seg(3, tr - ta); seg(4, 4); seg(5, 60);
    loopback_req = 1'($urandom_range(0, 1));
    enable = 1'b1;
    for (int k = 1; k <= tr + 63; k++) begin
      cyc();
      loopback_req = 1'($urandom_range(0, 1));
      if (k == L) rx_gt_locked = 1'b1;
      if (k == A) rx_aligned = 1'b1;
      if (k >= tr + 4) send_req = 1'($urandom_range(0, 1));
      rx_data_fail = (k >= tr + 6 && k < tr + 6 + 2 * npulse) ? ((k - tr - 6) % 2 == 0) : 1'b0;
    end
    check("bringup_fail_events", fail_events, npulse);

    // one-cycle drop of lock or aligned in RUN
    send_req = 1'b1;
    if ($urandom_range(0, 1) == 1) rx_gt_locked = 1'b0; else rx_aligned = 1'b0;
    seg(5, 2); seg(6, 1); seg(1, 8); seg(2, 1); seg(3, 1); seg(4, 4); seg(5, 10);
    for (int k = 1; k <= 27; k++) begin
      cyc();
      if (k == 1) begin rx_gt_locked = 1'b1; rx_aligned = 1'b1; end
    end

    // lock never rises: three timeouts end in FAIL, enable low releases it
    enable = 1'b0; rx_gt_locked = 1'b0; rx_aligned = 1'b0; send_req = 1'b0;
    seg(0, 3); run(3);
    enable = 1'b1;
    repeat (3) begin seg(1, 8); seg(2, 100); seg(6, 1); end
    seg(7, 6); run(333);
    check("fail_retry_cnt", retry_cnt, 2);
    enable = 1'b0;
    seg(0, 2); run(2);

    // lock arriving right around the WAIT_LOCK timeout
    j = 105 + $urandom_range(0, 2);
    enable = 1'b1;
    if (j + 3 <= 109) begin
      seg(1, 8); seg(2, j - 6); seg(3, 123 - j);
    end else begin
      seg(1, 8); seg(2, 100); seg(6, 1); seg(1, 8); seg(2, 1); seg(3, 7);
    end
    for (int k = 1; k <= 125; k++) begin
      cyc();
      if (k == j) rx_gt_locked = 1'b1;
    end
    enable = 1'b0;
    seg(0, 2); run(2);

    // enable dropped mid-RESTART truncates the pulse
    rx_gt_locked = 1'b1; rx_aligned = 1'b1;
    seg(0, 3); run(3);
    x = $urandom_range(0, 2);
    enable = 1'b1;
    seg(1, 8); seg(2, 1); seg(3, 1); seg(4, x + 1); seg(0, 3);
    for (int k = 1; k <= 14 + x; k++) begin
      cyc();
      if (k == 11 + x) enable = 1'b0;
    end

    // asynchronous reset while in RUN
    enable = 1'b1; loopback_req = 1'b1; send_req = 1'b1;
    seg(1, 8); seg(2, 1); seg(3, 1); seg(4, 4); seg(5, 10);
    for (int k = 1; k <= 24; k++) begin
      cyc();
      rx_data_fail = (k == 16);
    end
    #2 sys_reset = 1'b1;
    #1;
    check("arst_state", state, 0);
    check("arst_sys_reset", cmac_sys_reset, 1);
    check("arst_restart", cmac_restart, 0);
    check("arst_send_pkts", cmac_send_pkts, 0);
    check("arst_loopback_en", cmac_loopback_en, 0);
    check("arst_retry_cnt", retry_cnt, 0);
    check("arst_link_up", link_up, 0);
    check("arst_link_fail", link_fail, 0);
    check("arst_fail_events", fail_events, 0);
    enable = 1'b0;
    step();
    sys_reset = 1'b0;
    model_reset();
    seg(0, 2); run(2);

    // fail_events saturation
    loopback_req = 1'($urandom_range(0, 1));
    enable = 1'b1;
    seg(1, 8); seg(2, 1); seg(3, 1); seg(4, 4); seg(5, 2 * NP + 10);
    for (int k = 1; k <= 2 * NP + 24; k++) begin
      cyc();
      send_req = 1'($urandom_range(0, 1));
      rx_data_fail = (k >= 15 && k < 15 + 2 * NP) ? ((k - 15) % 2 == 0) : 1'b0;
    end
    check("fe_saturated", fail_events, 16'hFFFF);

`ifdef FREQ_CHECK_EN
    // out-of-range refclk blocks lock acceptance until a good measurement arrives
    enable = 1'b0; rx_aligned = 1'b0; send_req = 1'b0; freq_update = 1'b0;
    seg(0, 3); run(3);
    enable = 1'b1;
    seg(1, 8); seg(2, 100); seg(6, 1); seg(1, 8); seg(2, 4); seg(3, 5);
    for (int k = 1; k <= 126; k++) begin
      cyc();
      freq_update = (k == 3) || (k == 120);
      freq_value  = (k == 3) ? 32'd156250000 : 32'd161132812;
    end
    enable = 1'b0; freq_update = 1'b1;
    seg(0, 2); run(2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
